// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and status controller for the async FIFO.
// Owns the binary/Gray write pointer and drives the RAM write address.
// Brings the read-side Gray pointer across through a flop chain.
// Produces registered full, almost-full and fill level, plus a sticky
// overflow flag.
module wptr_full_ctrl #(
    parameter int ADDR_SIZE    = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 12
) (
    input  logic                 w_clk,
    input  logic                 w_rst,
    input  logic                 w_en,
    input  logic [ADDR_SIZE:0]   r_ptr_gray,
    input  logic                 w_ovf_clr,
    output logic [ADDR_SIZE-1:0] w_addr,
    output logic                 w_wr,
    output logic [ADDR_SIZE:0]   w_ptr_gray,
    output logic                 w_full,
    output logic                 w_afull,
    output logic [ADDR_SIZE:0]   w_level,
    output logic                 w_overflow
);

    localparam int PW = ADDR_SIZE + 1;
    localparam logic [ADDR_SIZE:0] AFULL_LVL = PW'(AFULL_THRESH);

    logic [ADDR_SIZE:0] w_ptr_bin;
    logic [ADDR_SIZE:0] w_ptr_bin_next;
    logic [ADDR_SIZE:0] w_ptr_gray_next;
    logic [ADDR_SIZE:0] rq_gray;
    logic [ADDR_SIZE:0] rq_bin;
    logic [ADDR_SIZE:0] full_pattern;
    logic [ADDR_SIZE:0] level_next;
    logic [ADDR_SIZE:0] sync_q [SYNC_STAGES];
    logic               wr;

    // A write is accepted only while not full; the strobe is held low in reset.
    assign wr     = w_en & ~w_full;
    assign w_wr   = wr & w_rst;
    assign w_addr = w_ptr_bin[ADDR_SIZE-1:0];

    assign rq_gray = sync_q[SYNC_STAGES-1];

    // Read pointer synchroniser: a bare flop chain, nothing between stages.
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            // NOTE: the synchroniser array is real state that the full and
            // level compares depend on, so every stage is reset, not just the
            // first; an unreset stage would make full/level garbage after reset.
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let each stage capture the previous
            // stage's old value; blocking here would collapse the chain to one flop.
            sync_q[0] <= r_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Gray-to-binary of the synchronised read pointer: bit i is the XOR of
    // all Gray bits from i upward.
    always_comb begin
        // NOTE: default every output of a combinational block first so no
        // path can leave a bit unassigned and infer a latch.
        rq_bin = '0;
        for (int i = 0; i <= ADDR_SIZE; i++) begin
            rq_bin[i] = ^(rq_gray >> i);
        end
    end

    // Next-state pointer, full pattern and look-ahead level.
    always_comb begin
        w_ptr_bin_next  = w_ptr_bin + {{ADDR_SIZE{1'b0}}, wr};
        w_ptr_gray_next = w_ptr_bin_next ^ (w_ptr_bin_next >> 1);
        // Full: the write pointer sits one lap ahead of the read pointer,
        // which in Gray code flips the top two bits and keeps the rest.
        full_pattern    = {~rq_gray[ADDR_SIZE:ADDR_SIZE-1], rq_gray[ADDR_SIZE-2:0]};
        level_next      = w_ptr_bin_next - rq_bin;
    end

    // Pointer and status registers, all updated from the look-ahead values.
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            w_ptr_bin  <= '0;
            w_ptr_gray <= '0;
            w_full     <= 1'b0;
            w_afull    <= 1'b0;
            w_level    <= '0;
        end else begin
            w_ptr_bin  <= w_ptr_bin_next;
            w_ptr_gray <= w_ptr_gray_next;
            w_full     <= (w_ptr_gray_next == full_pattern);
            w_afull    <= (level_next >= AFULL_LVL);
            w_level    <= level_next;
        end
    end

    // Sticky overflow: a write attempted while full sets it; set beats clear.
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            w_overflow <= 1'b0;
        end else begin
            w_overflow <= (w_en & w_full) | (w_overflow & ~w_ovf_clr);
        end
    end

endmodule
